// File: rtl/sample_serializer_if.sv
// Bus bundle for sample_serializer: FIFO read side, byte stream side and
// the sample-count readout. "master" is the serializer, "slave" is the
// surrounding logic (FIFO, FX2 byte consumer, host length request).
interface sample_serializer_if #(
    parameter int SAMPLE_BYTES = 6,
    parameter int COUNT_W      = 16
);
    // FIFO read side (show-ahead)
    logic                      sample_rdy;
    logic [8*SAMPLE_BYTES-1:0] sample;
    logic                      sample_ack;

    // byte stream towards the FX2
    logic                      data_rdy;
    logic [7:0]                data;
    logic                      data_ack;

    // sample-count readout
    logic                      readout_clr;
    logic [COUNT_W-1:0]        length;
    logic                      overflow;

    modport master (
        input  sample_rdy, sample, data_ack, readout_clr,
        output sample_ack, data_rdy, data, length, overflow
    );

    modport slave (
        output sample_rdy, sample, data_ack, readout_clr,
        input  sample_ack, data_rdy, data, length, overflow
    );
endinterface

// File: rtl/sample_serializer.sv
// sample_serializer: pops SAMPLE_BYTES-byte samples from a show-ahead FIFO
// and streams them out one byte at a time with a ready/ack handshake, in
// either byte order. Also keeps a saturating count of transferred samples
// with snapshot-and-clear readout.
//
// Optional build macro SAMPLE_SERIALIZER_HEADER_EN: prefixes each sample
// with a header byte {1'b1, seq[6:0]}; seq counts samples and wraps at 127.
//
// SAMPLE_BYTES must be >= 2: the FIFO empty flag gets SAMPLE_BYTES-1 cycles
// after the pop before IDLE samples sample_rdy again.
module sample_serializer #(
    parameter int SAMPLE_BYTES = 6,
    parameter bit MSB_FIRST    = 1'b1,
    parameter int COUNT_W      = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    sample_serializer_if.master  bus
);

    localparam int SW    = 8 * SAMPLE_BYTES;
    localparam int IDX_W = $clog2(SAMPLE_BYTES);

    localparam logic [IDX_W-1:0]   LAST_IDX = IDX_W'(SAMPLE_BYTES - 1);
    localparam logic [IDX_W-1:0]   IDX_ONE  = IDX_W'(1);
    localparam logic [COUNT_W-1:0] CNT_MAX  = '1;
    localparam logic [COUNT_W-1:0] CNT_ONE  = COUNT_W'(1);

`ifdef SAMPLE_SERIALIZER_HEADER_EN
    typedef enum logic [1:0] {IDLE, HEADER, SEND} state_t;
`else
    typedef enum logic {IDLE, SEND} state_t;
`endif

    state_t           state;
    state_t           state_nxt;
    logic [SW-1:0]    sreg;
    logic [IDX_W-1:0] idx;
    logic [7:0]       data_nxt;
    logic             capture;
    logic             advance;
    logic             last_byte;
    logic [COUNT_W-1:0] count;

`ifdef SAMPLE_SERIALIZER_HEADER_EN
    logic [6:0]       seq;
    logic             hdr_done;
`endif

    // The byte that goes out first from a word, given the byte order.
    function automatic logic [7:0] first_byte(input logic [SW-1:0] w);
        if (MSB_FIRST)
            return w[SW-1 -: 8];
        else
            return w[7:0];
    endfunction

    // Drop the byte just sent so the next one sits in the first_byte slot.
    function automatic logic [SW-1:0] drop_byte(input logic [SW-1:0] w);
        if (MSB_FIRST)
            return w << 8;
        else
            return w >> 8;
    endfunction

    assign last_byte = (idx == LAST_IDX);

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Next state, handshake strobes and the next value of the output byte.
    always_comb begin
        state_nxt = state;
        capture   = 1'b0;
        advance   = 1'b0;
        data_nxt  = bus.data;
`ifdef SAMPLE_SERIALIZER_HEADER_EN
        hdr_done  = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (bus.sample_rdy) begin
                    capture = 1'b1;
`ifdef SAMPLE_SERIALIZER_HEADER_EN
                    state_nxt = HEADER;
                    data_nxt  = {1'b1, seq};
`else
                    state_nxt = SEND;
                    data_nxt  = first_byte(bus.sample);
`endif
                end
            end
`ifdef SAMPLE_SERIALIZER_HEADER_EN
            HEADER: begin
                if (bus.data_ack) begin
                    hdr_done  = 1'b1;
                    state_nxt = SEND;
                    data_nxt  = first_byte(sreg);
                end
            end
`endif
            SEND: begin
                if (bus.data_ack) begin
                    advance = 1'b1;
                    if (last_byte)
                        state_nxt = IDLE;
                    else
                        data_nxt = first_byte(drop_byte(sreg));
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Output registers: pop pulse on the capture edge, byte valid while busy.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.sample_ack <= 1'b0;
            bus.data_rdy   <= 1'b0;
            bus.data       <= 8'h00;
        end else begin
            bus.sample_ack <= capture;
            bus.data_rdy   <= (state_nxt != IDLE);
            bus.data       <= data_nxt;
        end
    end

    // Shift register and byte index; the index only tells us when the
    // last byte has gone, the byte itself always comes from the top/bottom.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sreg <= '0;
            idx  <= '0;
        end else if (capture) begin
            sreg <= bus.sample;
            idx  <= '0;
        end else if (advance) begin
            sreg <= drop_byte(sreg);
            idx  <= last_byte ? '0 : idx + IDX_ONE;
        end
    end

`ifdef SAMPLE_SERIALIZER_HEADER_EN
    // Header sequence number, bumped once the header byte is taken.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            seq <= 7'd0;
        else if (hdr_done)
            seq <= seq + 7'd1;
    end
`endif

    // Saturating sample counter with snapshot-and-clear; a pop in the
    // readout cycle lands in this snapshot rather than the next one.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count        <= '0;
            bus.length   <= '0;
            bus.overflow <= 1'b0;
        end else if (bus.readout_clr) begin
            bus.length   <= (bus.sample_ack && count != CNT_MAX) ? count + CNT_ONE : count;
            count        <= '0;
            bus.overflow <= 1'b0;
        end else if (bus.sample_ack) begin
            if (count == CNT_MAX)
                bus.overflow <= 1'b1;
            else
                count <= count + CNT_ONE;
        end
    end

endmodule

// File: tb/tb_sample_serializer.sv
// Directed bench for sample_serializer. Three instances share one stimulus:
// u0 default (MSB first, 16-bit count), u1 LSB first, u2 with a 4-bit count.
`timescale 1ns/1ps
module tb_sample_serializer;

`ifdef SAMPLE_SERIALIZER_HEADER_EN
    localparam int HDR = 1;
`else
    localparam int HDR = 0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        sample_rdy;
    logic [47:0] sample;
    logic        data_ack;
    logic        readout_clr;
    logic [6:0]  seq_exp;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    sample_serializer_if #(.SAMPLE_BYTES(6), .COUNT_W(16)) b0 ();
    sample_serializer_if #(.SAMPLE_BYTES(6), .COUNT_W(16)) b1 ();
    sample_serializer_if #(.SAMPLE_BYTES(6), .COUNT_W(4))  b2 ();

    assign b0.sample_rdy  = sample_rdy;
    assign b0.sample      = sample;
    assign b0.data_ack    = data_ack;
    assign b0.readout_clr = readout_clr;
    assign b1.sample_rdy  = sample_rdy;
    assign b1.sample      = sample;
    assign b1.data_ack    = data_ack;
    assign b1.readout_clr = readout_clr;
    assign b2.sample_rdy  = sample_rdy;
    assign b2.sample      = sample;
    assign b2.data_ack    = data_ack;
    assign b2.readout_clr = readout_clr;

    sample_serializer #(.SAMPLE_BYTES(6), .MSB_FIRST(1'b1), .COUNT_W(16)) u0 (
        .clk(clk), .reset(reset), .bus(b0.master));
    sample_serializer #(.SAMPLE_BYTES(6), .MSB_FIRST(1'b0), .COUNT_W(16)) u1 (
        .clk(clk), .reset(reset), .bus(b1.master));
    sample_serializer #(.SAMPLE_BYTES(6), .MSB_FIRST(1'b1), .COUNT_W(4)) u2 (
        .clk(clk), .reset(reset), .bus(b2.master));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Offer one sample, then follow it byte by byte. Returns in the idle
    // cycle after the last byte, before the next rising edge.
    task automatic run_sample(input logic [47:0] s, input int stall_at,
                              input int stall_len, input bit clr_first);
        logic [7:0] e_msb;
        logic [7:0] e_lsb;
        sample     = s;
        sample_rdy = 1'b1;
        @(posedge clk); #1;
        sample_rdy  = 1'b0;
        readout_clr = clr_first;
`ifdef SAMPLE_SERIALIZER_HEADER_EN
        @(negedge clk);
        chk("hdr_rdy", b0.data_rdy, 1);
        chk("hdr_ack", b0.sample_ack, 1);
        chk("hdr_byte", b0.data, {1'b1, seq_exp});
        @(posedge clk); #1;
        readout_clr = 1'b0;
        seq_exp++;
`endif
        for (int i = 0; i < 6; i++) begin
            e_msb = s[8*(5-i) +: 8];
            e_lsb = s[8*i +: 8];
            if (i == stall_at) begin
                data_ack = 1'b0;
                repeat (stall_len) begin
                    @(negedge clk);
                    chk("stall_rdy", b0.data_rdy, 1);
                    chk("stall_byte", b0.data, e_msb);
                    @(posedge clk); #1;
                end
                data_ack = 1'b1;
            end
            @(negedge clk);
            chk("byte_rdy", b0.data_rdy, 1);
            chk("byte_msb", b0.data, e_msb);
            chk("byte_lsb", b1.data, e_lsb);
            chk("byte_ack", b0.sample_ack, (i == 0 && HDR == 0) ? 1 : 0);
            @(posedge clk); #1;
            readout_clr = 1'b0;
        end
        @(negedge clk);
        chk("gap_rdy", b0.data_rdy, 0);
        chk("gap_ack", b0.sample_ack, 0);
    endtask

    task automatic do_clr;
        readout_clr = 1'b1;
        @(posedge clk); #1;
        readout_clr = 1'b0;
    endtask

    initial begin
        reset       = 1'b1;
        sample_rdy  = 1'b0;
        sample      = '0;
        data_ack    = 1'b1;
        readout_clr = 1'b0;
        seq_exp     = 7'd0;
        #1;
        chk("rst_rdy", b0.data_rdy, 0);
        chk("rst_data", b0.data, 8'h00);
        chk("rst_ack", b0.sample_ack, 0);
        chk("rst_len", b0.length, 0);
        chk("rst_ovf", b0.overflow, 0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        // fe,ed,de,ad,be,ed on u0; ed,be,ad,de,ed,fe on u1
        run_sample(48'hfeeddeadbeed, -1, 0, 1'b0);
        // consumer stalls 5 cycles on byte 2 (de), then resumes with ad
        run_sample(48'hfeeddeadbeed, 2, 5, 1'b0);

        do_clr();
        chk("len_two", b0.length, 2);
        chk("ovf_two", b0.overflow, 0);

        run_sample(48'h0123456789ab, -1, 0, 1'b0);
        run_sample(48'h5a5a00ff1234, -1, 0, 1'b0);
        run_sample(48'h80000000007f, -1, 0, 1'b0);
        // fourth pop coincides with the readout
        run_sample(48'hc0ffee123456, -1, 0, 1'b1);
        chk("len_coinc", b0.length, 4);
        do_clr();
        chk("len_cleared", b0.length, 0);

        // 17 samples into a 4-bit counter
        for (int i = 0; i < 17; i++) begin
            run_sample({8'(i), 8'hA5, 8'(i * 3), 8'h3C, 8'(255 - i), 8'h01}, -1, 0, 1'b0);
            if (i == 14) chk("ovf_at_15", b2.overflow, 0);
            if (i == 15) chk("ovf_at_16", b2.overflow, 1);
        end
        chk("ovf_small", b2.overflow, 1);
        chk("ovf_wide", b0.overflow, 0);
        do_clr();
        chk("len_sat", b2.length, 15);
        chk("ovf_clr", b2.overflow, 0);
        chk("len_17", b0.length, 17);

        // reset while byte 3 (ad) is on the bus
        sample     = 48'hfeeddeadbeed;
        sample_rdy = 1'b1;
        @(posedge clk); #1;
        sample_rdy = 1'b0;
        repeat (3 + HDR) @(posedge clk);
        #1;
        chk("pre_rst_byte", b0.data, 8'had);
        reset = 1'b1;
        #1;
        chk("midrst_rdy", b0.data_rdy, 0);
        chk("midrst_data", b0.data, 8'h00);
        chk("midrst_len", b0.length, 0);
        @(posedge clk); #1;
        reset   = 1'b0;
        seq_exp = 7'd0;
        run_sample(48'h010203040506, -1, 0, 1'b0);

`ifdef SAMPLE_SERIALIZER_HEADER_EN
        // headers 80..ff then wrap to 80
        reset = 1'b1;
        @(posedge clk); #1;
        reset   = 1'b0;
        seq_exp = 7'd0;
        for (int i = 0; i < 129; i++)
            run_sample({8'(i), 40'h1122334455}, -1, 0, 1'b0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
